// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the RV32I multicycle control unit.
//   - state_e        : control FSM states (also exported on the debug port)
//   - ALU_*          : ALU op codes, {func7[5], func3} encoding
//   - OPC_*          : RV32I major opcodes
//   - imm_sel_e      : immediate format select
//   - wsel_e         : register file write-data select
//   - pc_sel_e       : next-PC select
//   - instr_class_e  : coarse instruction class used to steer the FSM
//   - branch_taken() : branch condition from func3 and comparator flags
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd13;
    localparam logic [3:0] ALU_COPY = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Operand B select encodings
    localparam logic [1:0] BSEL_RS2  = 2'd0;
    localparam logic [1:0] BSEL_IMM  = 2'd1;
    localparam logic [1:0] BSEL_FOUR = 2'd2;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        WSEL_ALU = 2'd0,
        WSEL_MEM = 2'd1,
        WSEL_PC4 = 2'd2
    } wsel_e;

    typedef enum logic [1:0] {
        PCSEL_PLUS4     = 2'd0,
        PCSEL_ALU       = 2'd1,
        PCSEL_ALU_ALIGN = 2'd2
    } pc_sel_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5
    } instr_class_e;

    // func3 1x0 / 1x1 pairs are the inverted forms; 010/011 are not branches
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic eq,
                                          input logic lt,
                                          input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = eq;
            3'b001:  taken = ~eq;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/cu_fsm_alu_dec.sv
// alu_dec: combinational instruction decoder for the control unit.
// Ports:
//   opcode, funct3, funct7 : instruction fields from the IR
//   alu_op                 : ALU op code used in EXEC
//   alu_a_sel              : 0 = rs1, 1 = PC
//   alu_b_sel              : 0 = rs2, 1 = imm, 2 = constant 4
//   imm_sel                : immediate format
//   instr_class            : coarse class steering the FSM
//   illegal                : unknown opcode or OP with bad func7
module alu_dec
    import cu_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output logic [3:0]   alu_op,
    output logic         alu_a_sel,
    output logic [1:0]   alu_b_sel,
    output imm_sel_e     imm_sel,
    output instr_class_e instr_class,
    output logic         illegal
);

    // Illegal instructions fall through as CLS_ALU so that, without the trap
    // build, they run EXEC -> WB like any ALU op and the FSM suppresses rf_we.
    always_comb begin
        alu_op      = ALU_ADD;
        alu_a_sel   = 1'b0;
        alu_b_sel   = BSEL_RS2;
        imm_sel     = IMM_I;
        instr_class = CLS_ALU;
        illegal     = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_op  = {funct7[5], funct3};
                illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
            OPC_OP_IMM: begin
                // func7[5] only distinguishes srai from srli; for every other
                // OP-IMM those bits are immediate, not an op modifier
                alu_op    = {(funct3 == 3'b101) & funct7[5], funct3};
                alu_b_sel = BSEL_IMM;
            end
            OPC_LUI: begin
                alu_op    = ALU_COPY;
                alu_b_sel = BSEL_IMM;
                imm_sel   = IMM_U;
            end
            OPC_AUIPC: begin
                alu_a_sel = 1'b1;
                alu_b_sel = BSEL_IMM;
                imm_sel   = IMM_U;
            end
            OPC_LOAD: begin
                alu_b_sel   = BSEL_IMM;
                instr_class = CLS_LOAD;
            end
            OPC_STORE: begin
                alu_b_sel   = BSEL_IMM;
                imm_sel     = IMM_S;
                instr_class = CLS_STORE;
            end
            OPC_BRANCH: begin
                alu_a_sel   = 1'b1;
                alu_b_sel   = BSEL_IMM;
                imm_sel     = IMM_B;
                instr_class = CLS_BRANCH;
            end
            OPC_JAL: begin
                alu_a_sel   = 1'b1;
                alu_b_sel   = BSEL_IMM;
                imm_sel     = IMM_J;
                instr_class = CLS_JAL;
            end
            OPC_JALR: begin
                alu_b_sel   = BSEL_IMM;
                instr_class = CLS_JALR;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cu_fsm.sv
// cu_fsm: multicycle control unit for the RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath.
// Build option: define CU_ILLEGAL_TRAP_EN to send illegal instructions to a
// sticky TRAP state; otherwise they execute as a NOP and `illegal` is 0.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   ir                         : instruction register contents
//   mem_ack                    : memory completion
//   br_eq, br_lt, br_ltu       : rs1/rs2 comparator flags
//   alu_op, alu_a_sel,
//   alu_b_sel, imm_sel         : ALU control in EXEC
//   ir_we, aluout_we           : IR / ALU-out register enables
//   rf_we, rf_wsel             : register file write control
//   pc_we, pc_sel              : PC update control
//   mem_req, mem_we,
//   mem_addr_sel               : memory request handshake
//   illegal                    : illegal-instruction flag
//   state                      : current state, debug only
module cu_fsm
    import cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        mem_ack,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    output logic [3:0]  alu_op,
    output logic        alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [2:0]  imm_sel,
    output logic        ir_we,
    output logic        aluout_we,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        illegal,
    output logic [2:0]  state
);

    state_e       state_q, state_d;
    logic         started_q, started_d;

    logic [3:0]   dec_alu_op;
    logic         dec_a_sel;
    logic [1:0]   dec_b_sel;
    imm_sel_e     dec_imm_sel;
    instr_class_e dec_class;
    logic         dec_illegal;

    // Register-number and immediate fields belong to the datapath
    logic unused_fields;
    assign unused_fields = ^{ir[24:15], ir[11:7], (MEM_TIMEOUT != 0)};

    alu_dec u_alu_dec (
        .opcode      (ir[6:0]),
        .funct3      (ir[14:12]),
        .funct7      (ir[31:25]),
        .alu_op      (dec_alu_op),
        .alu_a_sel   (dec_a_sel),
        .alu_b_sel   (dec_b_sel),
        .imm_sel     (dec_imm_sel),
        .instr_class (dec_class),
        .illegal     (dec_illegal)
    );

    assign state = state_q;

    // started_q keeps every output quiet while in reset and for the gap
    // between reset release and the first clock edge, so an aborted access
    // cannot restart until FETCH is properly entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        started_d    = 1'b1;
        alu_op       = ALU_ADD;
        alu_a_sel    = 1'b0;
        alu_b_sel    = BSEL_RS2;
        imm_sel      = IMM_I;
        ir_we        = 1'b0;
        aluout_we    = 1'b0;
        rf_we        = 1'b0;
        rf_wsel      = WSEL_ALU;
        pc_we        = 1'b0;
        pc_sel       = PCSEL_PLUS4;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        illegal      = 1'b0;

        if (started_q) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_we   = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
`ifdef CU_ILLEGAL_TRAP_EN
                    state_d = dec_illegal ? ST_TRAP : ST_EXEC;
`else
                    state_d = ST_EXEC;
`endif
                end
                ST_EXEC: begin
                    alu_op    = dec_alu_op;
                    alu_a_sel = dec_a_sel;
                    alu_b_sel = dec_b_sel;
                    imm_sel   = dec_imm_sel;
                    aluout_we = 1'b1;
                    case (dec_class)
                        CLS_BRANCH: begin
                            // ALU computes PC+imm this cycle; a taken branch
                            // loads it straight into PC, skipping WB
                            pc_we   = 1'b1;
                            pc_sel  = branch_taken(ir[14:12], br_eq, br_lt, br_ltu)
                                      ? PCSEL_ALU : PCSEL_PLUS4;
                            state_d = ST_FETCH;
                        end
                        CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                        default:             state_d = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (dec_class == CLS_STORE);
                    if (mem_ack) begin
                        if (dec_class == CLS_STORE) begin
                            pc_we   = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    // Illegal instructions reaching here only advance the PC
                    rf_we   = ~dec_illegal;
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                    case (dec_class)
                        CLS_LOAD: rf_wsel = WSEL_MEM;
                        CLS_JAL: begin
                            rf_wsel = WSEL_PC4;
                            pc_sel  = PCSEL_ALU;
                        end
                        CLS_JALR: begin
                            rf_wsel = WSEL_PC4;
                            pc_sel  = PCSEL_ALU_ALIGN;
                        end
                        default: ;
                    endcase
                end
                ST_TRAP: begin
`ifdef CU_ILLEGAL_TRAP_EN
                    illegal = 1'b1;
`endif
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm: directed self-checking bench for cu_fsm.
// Walks representative instructions through the FSM with hand-computed
// expected control values, including memory wait states, branch taken /
// not taken, illegal-instruction handling for the current build, and reset
// in the middle of a memory access.
module tb_cu_fsm;

    logic        clk;
    logic        rst_n;
    logic [31:0] ir;
    logic        mem_ack;
    logic        br_eq;
    logic        br_lt;
    logic        br_ltu;
    logic [3:0]  alu_op;
    logic        alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic [2:0]  imm_sel;
    logic        ir_we;
    logic        aluout_we;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        illegal;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    cu_fsm #(.MEM_TIMEOUT(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir           (ir),
        .mem_ack      (mem_ack),
        .br_eq        (br_eq),
        .br_lt        (br_lt),
        .br_ltu       (br_ltu),
        .alu_op       (alu_op),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .imm_sel      (imm_sel),
        .ir_we        (ir_we),
        .aluout_we    (aluout_we),
        .rf_we        (rf_we),
        .rf_wsel      (rf_wsel),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .illegal      (illegal),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the directed sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive all DUT inputs except reset
    task automatic applyStimulus(input logic [31:0] instr, input logic ack,
                                 input logic eq, input logic lt, input logic ltu);
        ir      = instr;
        mem_ack = ack;
        br_eq   = eq;
        br_lt   = lt;
        br_ltu  = ltu;
    endtask

    // One comparison; observed values are zero-extended to 32 bits
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Move just past the next rising edge
    task automatic nextEdge();
        @(posedge clk);
        #2;
    endtask

    // FETCH with immediate ack, then DECODE; returns just after the EXEC edge
    task automatic fetchDecode(input string name, input logic [31:0] instr);
        applyStimulus(instr, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput({name, "_fetch_state"}, 32'(state), 32'd0);
        checkOutput({name, "_fetch_req"}, 32'(mem_req), 32'd1);
        checkOutput({name, "_fetch_irwe"}, 32'(ir_we), 32'd1);
        checkOutput({name, "_fetch_addrsel"}, 32'(mem_addr_sel), 32'd0);
        nextEdge();
        mem_ack = 1'b0;
        #1;
        checkOutput({name, "_decode_state"}, 32'(state), 32'd1);
        checkOutput({name, "_decode_req"}, 32'(mem_req), 32'd0);
        nextEdge();
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextEdge();
        nextEdge();
        #1;
        // Reset: everything quiet, state reads FETCH
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_enables", 32'({ir_we, aluout_we, rf_we, pc_we, mem_we}), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_req_before_edge", 32'(mem_req), 32'd0);
        nextEdge();
        #1;
        checkOutput("rel_req_after_edge", 32'(mem_req), 32'd1);
        checkOutput("rel_addrsel", 32'(mem_addr_sel), 32'd0);

        // One FETCH wait cycle: no ir_we, stays in FETCH
        applyStimulus(32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("fwait_irwe", 32'(ir_we), 32'd0);
        nextEdge();
        #1;
        checkOutput("fwait_state", 32'(state), 32'd0);
        checkOutput("fwait_req", 32'(mem_req), 32'd1);

        // add x3,x1,x2
        fetchDecode("add", 32'h002081B3);
        #1;
        checkOutput("add_exec_state", 32'(state), 32'd2);
        checkOutput("add_exec_op", 32'(alu_op), 32'd0);
        checkOutput("add_exec_sel", 32'({alu_a_sel, alu_b_sel}), 32'd0);
        checkOutput("add_exec_aluwe", 32'(aluout_we), 32'd1);
        nextEdge();
        #1;
        checkOutput("add_wb_state", 32'(state), 32'd4);
        checkOutput("add_wb_rfwe", 32'(rf_we), 32'd1);
        checkOutput("add_wb_wsel", 32'(rf_wsel), 32'd0);
        checkOutput("add_wb_pcwe", 32'(pc_we), 32'd1);
        checkOutput("add_wb_pcsel", 32'(pc_sel), 32'd0);
        nextEdge();
        #1;
        checkOutput("add_back_fetch", 32'(state), 32'd0);

        // sub x3,x1,x2
        fetchDecode("sub", 32'h402081B3);
        #1;
        checkOutput("sub_exec_op", 32'(alu_op), 32'd8);
        nextEdge();
        nextEdge();

        // srai x5,x5,3
        fetchDecode("srai", 32'h4032D293);
        #1;
        checkOutput("srai_exec_op", 32'(alu_op), 32'd13);
        checkOutput("srai_exec_bsel", 32'(alu_b_sel), 32'd1);
        checkOutput("srai_exec_imm", 32'(imm_sel), 32'd0);
        nextEdge();
        nextEdge();

        // srli x5,x5,3
        fetchDecode("srli", 32'h0032D293);
        #1;
        checkOutput("srli_exec_op", 32'(alu_op), 32'd5);
        nextEdge();
        nextEdge();

        // lui x1,0x12345
        fetchDecode("lui", 32'h123450B7);
        #1;
        checkOutput("lui_exec_op", 32'(alu_op), 32'd9);
        checkOutput("lui_exec_bsel", 32'(alu_b_sel), 32'd1);
        checkOutput("lui_exec_imm", 32'(imm_sel), 32'd3);
        nextEdge();
        #1;
        checkOutput("lui_wb_state", 32'(state), 32'd4);
        nextEdge();

        // beq x1,x2,8 taken
        fetchDecode("beqt", 32'h00208463);
        br_eq = 1'b1;
        #1;
        checkOutput("beqt_exec_state", 32'(state), 32'd2);
        checkOutput("beqt_exec_pcwe", 32'(pc_we), 32'd1);
        checkOutput("beqt_exec_pcsel", 32'(pc_sel), 32'd1);
        checkOutput("beqt_exec_sel", 32'({alu_a_sel, alu_b_sel, imm_sel}), 32'({1'b1, 2'd1, 3'd2}));
        checkOutput("beqt_exec_rfwe", 32'(rf_we), 32'd0);
        nextEdge();
        #1;
        checkOutput("beqt_back_fetch", 32'(state), 32'd0);

        // beq x1,x2,8 not taken
        fetchDecode("beqn", 32'h00208463);
        br_eq = 1'b0;
        #1;
        checkOutput("beqn_exec_pcwe", 32'(pc_we), 32'd1);
        checkOutput("beqn_exec_pcsel", 32'(pc_sel), 32'd0);
        nextEdge();
        #1;
        checkOutput("beqn_back_fetch", 32'(state), 32'd0);

        // lw x3,0(x1) with three MEM wait cycles
        fetchDecode("lw", 32'h0000A183);
        #1;
        checkOutput("lw_exec_sel", 32'({alu_b_sel, imm_sel}), 32'({2'd1, 3'd0}));
        nextEdge();
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("lw_memwait_state", 32'(state), 32'd3);
            checkOutput("lw_memwait_req", 32'({mem_req, mem_addr_sel, mem_we, pc_we}), 32'b1100);
            nextEdge();
        end
        mem_ack = 1'b1;
        #1;
        checkOutput("lw_memack_req", 32'({mem_req, mem_addr_sel, mem_we, pc_we}), 32'b1100);
        nextEdge();
        mem_ack = 1'b0;
        #1;
        checkOutput("lw_wb_state", 32'(state), 32'd4);
        checkOutput("lw_wb_wsel", 32'(rf_wsel), 32'd1);
        checkOutput("lw_wb_rfwe", 32'(rf_we), 32'd1);
        nextEdge();
        #1;
        checkOutput("lw_back_fetch", 32'(state), 32'd0);

        // sw x2,0(x1), zero-wait
        fetchDecode("sw", 32'h0020A023);
        #1;
        checkOutput("sw_exec_imm", 32'(imm_sel), 32'd1);
        nextEdge();
        mem_ack = 1'b1;
        #1;
        checkOutput("sw_mem_we", 32'(mem_we), 32'd1);
        checkOutput("sw_mem_pcwe", 32'(pc_we), 32'd1);
        checkOutput("sw_mem_pcsel", 32'(pc_sel), 32'd0);
        nextEdge();
        mem_ack = 1'b0;
        #1;
        checkOutput("sw_back_fetch", 32'(state), 32'd0);

        // jal x1,8
        fetchDecode("jal", 32'h008000EF);
        #1;
        checkOutput("jal_exec_sel", 32'({alu_a_sel, alu_b_sel, imm_sel}), 32'({1'b1, 2'd1, 3'd4}));
        nextEdge();
        #1;
        checkOutput("jal_wb_wsel", 32'(rf_wsel), 32'd2);
        checkOutput("jal_wb_pcsel", 32'(pc_sel), 32'd1);
        nextEdge();

        // jalr x1,4(x2)
        fetchDecode("jalr", 32'h004100E7);
        #1;
        checkOutput("jalr_exec_sel", 32'({alu_a_sel, alu_b_sel, imm_sel}), 32'({1'b0, 2'd1, 3'd0}));
        nextEdge();
        #1;
        checkOutput("jalr_wb_wsel", 32'(rf_wsel), 32'd2);
        checkOutput("jalr_wb_pcsel", 32'(pc_sel), 32'd2);
        checkOutput("jalr_wb_rfwe", 32'(rf_we), 32'd1);
        nextEdge();

        // Illegal instruction 0xFFFFFFFF
        fetchDecode("ill", 32'hFFFFFFFF);
`ifdef CU_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput("ill_trap_state", 32'(state), 32'd5);
            checkOutput("ill_trap_flag", 32'(illegal), 32'd1);
            checkOutput("ill_trap_enables",
                        32'({ir_we, aluout_we, rf_we, pc_we, mem_req, mem_we}), 32'd0);
            nextEdge();
        end
        rst_n = 1'b0;
        #1;
        checkOutput("ill_rst_flag", 32'(illegal), 32'd0);
        checkOutput("ill_rst_state", 32'(state), 32'd0);
        nextEdge();
        rst_n = 1'b1;
        nextEdge();
`else
        #1;
        checkOutput("ill_exec_state", 32'(state), 32'd2);
        checkOutput("ill_exec_flag", 32'(illegal), 32'd0);
        nextEdge();
        #1;
        checkOutput("ill_wb_state", 32'(state), 32'd4);
        checkOutput("ill_wb_rfwe", 32'(rf_we), 32'd0);
        checkOutput("ill_wb_pcwe", 32'(pc_we), 32'd1);
        checkOutput("ill_wb_pcsel", 32'(pc_sel), 32'd0);
        checkOutput("ill_wb_flag", 32'(illegal), 32'd0);
        nextEdge();
`endif
        #1;
        checkOutput("ill_after_state", 32'(state), 32'd0);
        checkOutput("ill_after_req", 32'(mem_req), 32'd1);

        // Reset pulse in the middle of a store MEM access
        fetchDecode("swr", 32'h0020A023);
        nextEdge();
        #1;
        checkOutput("swr_mem_active", 32'({mem_req, mem_we, mem_addr_sel}), 32'b111);
        rst_n = 1'b0;
        #1;
        checkOutput("swr_rst_req", 32'(mem_req), 32'd0);
        checkOutput("swr_rst_we", 32'(mem_we), 32'd0);
        checkOutput("swr_rst_state", 32'(state), 32'd0);
        nextEdge();
        mem_ack = 1'b1;
        #1;
        checkOutput("swr_hold_enables", 32'({ir_we, rf_we, pc_we, mem_req, mem_we}), 32'd0);
        rst_n = 1'b1;
        mem_ack = 1'b0;
        #1;
        checkOutput("swr_rel_req_before_edge", 32'(mem_req), 32'd0);
        nextEdge();
        #1;
        checkOutput("swr_rel_state", 32'(state), 32'd0);
        checkOutput("swr_rel_fetch", 32'({mem_req, mem_addr_sel, mem_we}), 32'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
